// File: rtl/alu_writeback_buffer.sv
// ---------------------------------------------------------------------------
// alu_writeback_buffer
//   Receiving end of the simple-ALU result path. ALU writeback packets are
//   queued in a small in-order FIFO; the oldest entry drains into the
//   arbitrated register-file write port, the bypass network and the
//   active-list control update. ready_o backpressures the ALU issue slot when
//   the FIFO is full, and recoverFlag_i discards everything buffered.
//
// Ports
//   clk, reset            clock, async active-high reset
//   recoverFlag_i         flush all buffered results (strobes masked this cycle)
//   pktValid_i, ready_o   ALU packet handshake
//   phyDest_i, destData_i, alID_i, destValid_i, flags_i   packet fields
//   rfWrReq_o, rfWrGrant_i          RF write-port request / same-cycle grant
//   rfWrEn_o, rfWrAddr_o, rfWrData_o   RF write
//   bypassValid_o, bypassTag_o, bypassData_o   bypass broadcast
//   ctrlValid_o, ctrlAlID_o, ctrlFlags_o       active-list update
//
// Drain-side outputs are combinational from the registered head entry plus
// the same-cycle grant/recover inputs; ready_o comes from registered state.
// ---------------------------------------------------------------------------
module alu_writeback_buffer #(
    parameter int unsigned SIZE_DATA           = 64,
    parameter int unsigned SIZE_PHYSICAL_LOG   = 7,
    parameter int unsigned SIZE_ACTIVELIST_LOG = 7,
    parameter int unsigned DEPTH               = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           recoverFlag_i,
    input  logic                           pktValid_i,
    output logic                           ready_o,
    input  logic [SIZE_PHYSICAL_LOG-1:0]   phyDest_i,
    input  logic [SIZE_DATA-1:0]           destData_i,
    input  logic [SIZE_ACTIVELIST_LOG-1:0] alID_i,
    input  logic                           destValid_i,
    input  logic [2:0]                     flags_i,
    output logic                           rfWrReq_o,
    input  logic                           rfWrGrant_i,
    output logic                           rfWrEn_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   rfWrAddr_o,
    output logic [SIZE_DATA-1:0]           rfWrData_o,
    output logic                           bypassValid_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]   bypassTag_o,
    output logic [SIZE_DATA-1:0]           bypassData_o,
    output logic                           ctrlValid_o,
    output logic [SIZE_ACTIVELIST_LOG-1:0] ctrlAlID_o,
    output logic [2:0]                     ctrlFlags_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Entry payload storage (qualified by valid_q, so no reset needed)
    logic [SIZE_PHYSICAL_LOG-1:0]   phy_mem   [DEPTH];
    logic [SIZE_DATA-1:0]           data_mem  [DEPTH];
    logic [SIZE_ACTIVELIST_LOG-1:0] alid_mem  [DEPTH];
    logic                           dv_mem    [DEPTH];
    logic [2:0]                     flags_mem [DEPTH];

    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic head_valid;
    logic head_dv;
    logic push;
    logic pop;

    assign ready_o    = (count_q < CNT_W'(DEPTH));
    assign head_valid = (count_q != '0) && valid_q[rd_ptr_q];
    assign head_dv    = dv_mem[rd_ptr_q];
    assign push       = pktValid_i && ready_o && !recoverFlag_i;
    // Entries that do not write a register drain without the RF port
    assign pop        = head_valid && !recoverFlag_i && (head_dv ? rfWrGrant_i : 1'b1);

    // Pointer, count and valid bookkeeping; recovery clears at the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else if (recoverFlag_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            // push and pop slots never coincide: that needs count 0 or DEPTH
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Payload write at the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            phy_mem[wr_ptr_q]   <= phyDest_i;
            data_mem[wr_ptr_q]  <= destData_i;
            alid_mem[wr_ptr_q]  <= alID_i;
            dv_mem[wr_ptr_q]    <= destValid_i;
            flags_mem[wr_ptr_q] <= flags_i;
        end
    end

    // Drain-side outputs: data/tag fields are zero outside a pop
    always_comb begin
        rfWrReq_o     = 1'b0;
        rfWrEn_o      = 1'b0;
        rfWrAddr_o    = '0;
        rfWrData_o    = '0;
        bypassValid_o = 1'b0;
        bypassTag_o   = '0;
        bypassData_o  = '0;
        ctrlValid_o   = 1'b0;
        ctrlAlID_o    = '0;
        ctrlFlags_o   = '0;

        rfWrReq_o = head_valid && head_dv && !recoverFlag_i;

        if (pop) begin
            ctrlValid_o = 1'b1;
            ctrlAlID_o  = alid_mem[rd_ptr_q];
            ctrlFlags_o = flags_mem[rd_ptr_q];
            if (head_dv) begin
                rfWrEn_o      = 1'b1;
                rfWrAddr_o    = phy_mem[rd_ptr_q];
                rfWrData_o    = data_mem[rd_ptr_q];
                bypassValid_o = 1'b1;
                bypassTag_o   = phy_mem[rd_ptr_q];
                bypassData_o  = data_mem[rd_ptr_q];
            end
        end
    end

endmodule
